// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the fetch/data memory port arbiter
// Purpose: FSM state and transaction owner encodings used by the arbiter.
// Ports: none.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory port bundle of the arbiter
// Purpose: groups the fetch request/response, data request/response and the
//   backing memory req/ack port into one bundle.
// Modports:
//   slave  - arbiter side: takes stage requests and memory ack/rdata, drives
//            responses, stalls and the memory request.
//   master - environment side: pipeline stages plus backing memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_starve.sv
// rtl/mem_port_arbiter_starve.sv - saturating count of data grants taken while fetch waits
// Purpose: counts data grants issued while fetch is pending; at_limit tells
//   the arbiter that fetch must win the next contended grant.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   inc       - data grant with fetch pending (saturates at LIMIT)
//   clr       - fetch grant (clear dominates inc)
//   at_limit  - count has reached LIMIT
module arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  import mem_arb_pkg::*;

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] MAX = W'(LIMIT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == MAX);
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data stages
// Purpose: grants one stage at a time (data first, fetch after STARVE_LIMIT
//   consecutive data grants), runs a req/ack memory transaction and returns
//   read data with a one-cycle valid pulse per stage.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   bus      - slave side of mem_port_arbiter_if (fetch, data, memory ports)
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);
  import mem_arb_pkg::*;

  arb_state_t        state, state_next;
  arb_owner_t        win;
  logic              grant, done_i, done_d;
  logic              at_limit, kill;
  logic              mem_req_q, mem_we_q, if_valid_q, d_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;

  arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (grant && (win == OWN_D) && bus.if_req),
    .clr      (grant && (win == OWN_I)),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_next;
  end

  // Data wins contention unless fetch has already been passed over STARVE_LIMIT times.
  always_comb begin
    state_next = state;
    unique case (state)
      ARB_IDLE: begin
        if (bus.d_req && !(bus.if_req && at_limit)) state_next = ARB_BUSY_D;
        else if (bus.if_req)                        state_next = ARB_BUSY_I;
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (bus.mem_ack) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    grant  = 1'b0;
    win    = OWN_I;
    done_i = 1'b0;
    done_d = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        grant = (state_next != ARB_IDLE);
        win   = (state_next == ARB_BUSY_D) ? OWN_D : OWN_I;
      end
      ARB_BUSY_I: done_i = bus.mem_ack;
      ARB_BUSY_D: done_d = bus.mem_ack;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      kill        <= 1'b0;
    end else begin
      if (grant) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= (win == OWN_D) && bus.d_we;
        mem_addr_q  <= (win == OWN_D) ? bus.d_addr : bus.if_addr;
        mem_wdata_q <= (win == OWN_D) ? bus.d_wdata : '0;
      end else if (done_i || done_d) begin
        mem_req_q <= 1'b0;
      end
      // A flush on the ack edge itself also kills the response.
      if_valid_q <= done_i && !kill && !bus.if_flush;
      if (done_i && !kill && !bus.if_flush) if_rdata_q <= bus.mem_rdata;
      d_valid_q <= done_d;
      if (done_d) d_rdata_q <= bus.mem_rdata;
      // Kill only lives for the fetch transaction it was raised in.
      kill <= (state == ARB_BUSY_I && !bus.mem_ack) ? (kill | bus.if_flush) : 1'b0;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_stall  = bus.if_req & ~if_valid_q;
  assign bus.d_stall   = bus.d_req & ~d_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dop_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bk_mem  [logic [31:0]];

  logic [31:0] fq[$];
  int          fflush_q[$];
  dop_t        dq[$];

  int  fixed_lat = 1;
  bit  rand_mode = 0;

  bit          open = 0;
  bit          own_d;
  bit          killed;
  int          lat, cnt, hi, f_plan, rise_cyc, cur_flush, wait_d = 0, max_hi = 0;
  logic        t_we;
  logic [31:0] t_addr, t_wdata;
  logic [31:0] if_exp, d_exp;
  logic        d_is_store;

  bit          glog[$];
  logic [31:0] alog[$];
  bit          welog[$];
  int          n_if_valid = 0, n_d_valid = 0;
  logic [31:0] last_if_data = '0, last_d_data = '0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] bk_rd(input logic [31:0] a);
    return bk_mem.exists(a) ? bk_mem[a] : init_word(a);
  endfunction

  // One clock: check what the last edge produced, then drive the next edge.
  task automatic step();
    logic e_if, e_d, e_ack, e_rst, o_req, o_we, o_ifv, o_dv, o_ifs, o_ds, exp_req;
    logic [31:0] o_addr, o_wdata, o_ifr, o_dr, a;
    bit closing, close_d, win_d;
    dop_t op;
    closing = 0;
    close_d = 0;
    @(negedge clk);
    cyc++;
    e_if = bus.if_req; e_d = bus.d_req; e_ack = bus.mem_ack; e_rst = rst;
    o_req = bus.mem_req; o_we = bus.mem_we; o_addr = bus.mem_addr; o_wdata = bus.mem_wdata;
    o_ifv = bus.if_valid; o_dv = bus.d_valid; o_ifr = bus.if_rdata; o_dr = bus.d_rdata;
    o_ifs = bus.if_stall; o_ds = bus.d_stall;

    vectors++;
    if (o_ifs !== (e_if & ~o_ifv)) begin
      miscompares++; $display("FAIL if_stall cyc %0d: got %b expected %b", cyc, o_ifs, e_if & ~o_ifv);
    end
    vectors++;
    if (o_ds !== (e_d & ~o_dv)) begin
      miscompares++; $display("FAIL d_stall cyc %0d: got %b expected %b", cyc, o_ds, e_d & ~o_dv);
    end

    if (e_rst) begin
      vectors++;
      if ({o_req, o_we, o_addr, o_wdata, o_ifv, o_dv, o_ifr, o_dr} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs cyc %0d: got req=%b we=%b addr=%h wdata=%h ifv=%b dv=%b ifr=%h dr=%h expected all zero",
                 cyc, o_req, o_we, o_addr, o_wdata, o_ifv, o_dv, o_ifr, o_dr);
      end
      open = 0;
      wait_d = 0;
    end else begin
      if (e_ack && open) begin
        closing = 1;
        close_d = own_d;
        vectors++;
        if (o_req !== 1'b0 || hi != lat || (cyc - rise_cyc) != lat) begin
          miscompares++;
          $display("FAIL completion_timing cyc %0d: got mem_req=%b high=%0d latency=%0d expected mem_req=0 high=%0d latency=%0d",
                   cyc, o_req, hi, cyc - rise_cyc, lat, lat);
        end
        vectors++;
        if (own_d) begin
          if (o_dv !== 1'b1 || o_ifv !== 1'b0 || (!d_is_store && o_dr !== d_exp)) begin
            miscompares++;
            $display("FAIL d_response cyc %0d: got dv=%b ifv=%b d_rdata=%h expected dv=1 ifv=0 d_rdata=%h",
                     cyc, o_dv, o_ifv, o_dr, d_exp);
          end
          n_d_valid += (o_dv === 1'b1) ? 1 : 0;
          if (!d_is_store) last_d_data = o_dr;
        end else if (killed) begin
          if (o_ifv !== 1'b0 || o_dv !== 1'b0) begin
            miscompares++;
            $display("FAIL flushed_fetch cyc %0d: got ifv=%b dv=%b expected 0 0", cyc, o_ifv, o_dv);
          end
        end else begin
          if (o_ifv !== 1'b1 || o_dv !== 1'b0 || o_ifr !== if_exp) begin
            miscompares++;
            $display("FAIL if_response cyc %0d: got ifv=%b dv=%b if_rdata=%h expected ifv=1 dv=0 if_rdata=%h",
                     cyc, o_ifv, o_dv, o_ifr, if_exp);
          end
          n_if_valid += (o_ifv === 1'b1) ? 1 : 0;
          last_if_data = o_ifr;
        end
        open = 0;
      end else begin
        vectors++;
        if (o_ifv !== 1'b0 || o_dv !== 1'b0) begin
          miscompares++;
          $display("FAIL spurious_valid cyc %0d: got ifv=%b dv=%b expected 0 0", cyc, o_ifv, o_dv);
        end
      end

      if (open) begin
        hi++;
        if (hi > max_hi) max_hi = hi;
        vectors++;
        if (o_req !== 1'b1 || o_addr !== t_addr || o_we !== t_we || o_wdata !== t_wdata) begin
          miscompares++;
          $display("FAIL bus_hold cyc %0d: got req=%b addr=%h we=%b wdata=%h expected req=1 addr=%h we=%b wdata=%h",
                   cyc, o_req, o_addr, o_we, o_wdata, t_addr, t_we, t_wdata);
        end
      end else if (!closing) begin
        // Port was free at the last edge: a grant must appear now iff someone asked.
        exp_req = e_if | e_d;
        vectors++;
        if (o_req !== exp_req) begin
          miscompares++;
          $display("FAIL grant_timing cyc %0d: got mem_req=%b expected %b", cyc, o_req, exp_req);
        end
        if (o_req === 1'b1 && exp_req) begin
          win_d = e_d && !(e_if && wait_d == LIMIT);
          vectors++;
          if (win_d) begin
            if (o_we !== bus.d_we || o_addr !== bus.d_addr || o_wdata !== bus.d_wdata) begin
              miscompares++;
              $display("FAIL data_grant cyc %0d: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                       cyc, o_we, o_addr, o_wdata, bus.d_we, bus.d_addr, bus.d_wdata);
            end
            if (e_if) wait_d++;
          end else begin
            if (o_we !== 1'b0 || o_addr !== bus.if_addr) begin
              miscompares++;
              $display("FAIL fetch_grant cyc %0d: got we=%b addr=%h expected we=0 addr=%h (data grants waited %0d)",
                       cyc, o_we, o_addr, bus.if_addr, wait_d);
            end
            wait_d = 0;
          end
          open = 1; own_d = win_d; killed = 0; hi = 1; cnt = 0; rise_cyc = cyc;
          if (max_hi < 1) max_hi = 1;
          t_we = o_we; t_addr = o_addr; t_wdata = o_wdata;
          lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
          f_plan = win_d ? -1 : cur_flush;
          glog.push_back(win_d);
          alog.push_back(o_addr);
          welog.push_back(o_we);
        end
      end
    end

    bus.mem_ack = 1'b0;
    bus.if_flush = 1'b0;
    bus.mem_rdata = $urandom;
    if (open) begin
      if (!own_d && cnt == f_plan) begin
        bus.if_flush = 1'b1;
        killed = 1;
      end
      if (cnt == lat - 1) begin
        bus.mem_ack = 1'b1;
        if (t_we) bk_mem[t_addr] = t_wdata;
        else      bus.mem_rdata = bk_rd(t_addr);
      end
      cnt++;
    end
    if (rand_mode && !(open && !own_d) && $urandom_range(0, 7) == 0) bus.if_flush = 1'b1;

    if (closing && !close_d) bus.if_req = 1'b0;
    if (closing && close_d)  bus.d_req = 1'b0;
    if (rand_mode && !e_rst) begin
      if (fq.size() == 0 && $urandom_range(0, 2) == 0) begin
        fq.push_back(32'h1000 + 32'($urandom_range(0, 63)) * 4);
        fflush_q.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
      end
      if (dq.size() == 0 && $urandom_range(0, 1) == 0) begin
        op.we = 1'($urandom_range(0, 1));
        op.addr = 32'h2000 + 32'($urandom_range(0, 15)) * 4;
        op.wdata = $urandom;
        dq.push_back(op);
      end
    end
    if (!rst && !bus.if_req && fq.size() > 0) begin
      a = fq.pop_front();
      cur_flush = fflush_q.pop_front();
      bus.if_addr = a;
      bus.if_req = 1'b1;
      if_exp = ref_rd(a);
    end
    if (!rst && !bus.d_req && dq.size() > 0) begin
      op = dq.pop_front();
      bus.d_we = op.we;
      bus.d_addr = op.addr;
      bus.d_wdata = op.wdata;
      bus.d_req = 1'b1;
      d_is_store = op.we;
      if (op.we) ref_mem[op.addr] = op.wdata;
      else       d_exp = ref_rd(op.addr);
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((open || fq.size() > 0 || dq.size() > 0 || bus.if_req || bus.d_req) && n < budget);
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b1;
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.mem_ack = 1'b0; bus.if_flush = 1'b0;
    fq.delete(); fflush_q.delete(); dq.delete();
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.if_req = 1'b1;
    bus.d_req = 1'b0;
    repeat (2) step();
    vectors++;
    if (bus.if_stall !== 1'b1 || bus.d_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall: got if_stall=%b d_stall=%b expected 1 0", bus.if_stall, bus.d_stall);
    end
    bus.if_req = 1'b0;
    step();
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_fetch_only();
    int n0;
    fixed_lat = 1;
    ref_mem[32'h10] = 32'h0050_0093;
    bk_mem[32'h10]  = 32'h0050_0093;
    n0 = n_if_valid;
    glog.delete(); alog.delete(); welog.delete();
    fq.push_back(32'h10); fflush_q.push_back(-1);
    run_until_idle(20);
    vectors++;
    if (n_if_valid - n0 != 1 || last_if_data !== 32'h0050_0093) begin
      miscompares++;
      $display("FAIL fetch_only: got %0d valids data=%h expected 1 valid data=00500093", n_if_valid - n0, last_if_data);
    end
    vectors++;
    if (alog.size() != 1 || alog[0] !== 32'h10 || welog[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_only_bus: got %0d grants addr=%h expected 1 grant addr=00000010 we=0", alog.size(), alog.size() ? alog[0] : 32'hx);
    end
  endtask

  task automatic test_store_load();
    dop_t op;
    int n0;
    fixed_lat = 1;
    n0 = n_d_valid;
    glog.delete(); alog.delete(); welog.delete();
    op.we = 1'b1; op.addr = 32'h40; op.wdata = 32'hDEAD_BEEF; dq.push_back(op);
    op.we = 1'b0; op.wdata = 32'h0; dq.push_back(op);
    run_until_idle(30);
    vectors++;
    if (n_d_valid - n0 != 2 || last_d_data !== 32'hDEAD_BEEF || bk_rd(32'h40) !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL store_load: got %0d valids load=%h memword=%h expected 2 valids load=deadbeef memword=deadbeef",
               n_d_valid - n0, last_d_data, bk_rd(32'h40));
    end
    vectors++;
    if (welog.size() != 2 || welog[0] !== 1'b1 || welog[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL store_load_we: got %0d grants expected store then load", welog.size());
    end
  endtask

  task automatic test_contention();
    dop_t op;
    bit exp_d;
    reset_dut(1);
    fixed_lat = 1;
    glog.delete();
    fq.push_back(32'h100); fflush_q.push_back(-1);
    fq.push_back(32'h104); fflush_q.push_back(-1);
    for (int i = 0; i < 8; i++) begin
      op.we = 1'b0; op.addr = 32'h200 + 32'(i) * 4; op.wdata = 32'h0;
      dq.push_back(op);
    end
    run_until_idle(100);
    vectors++;
    if (glog.size() != 10) begin
      miscompares++;
      $display("FAIL contention_count: got %0d grants expected 10", glog.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        exp_d = !(i == 4 || i == 9);
        vectors++;
        if (glog[i] !== exp_d) begin
          miscompares++;
          $display("FAIL contention_order grant %0d: got %s expected %s", i, glog[i] ? "D" : "I", exp_d ? "D" : "I");
        end
      end
    end
  endtask

  task automatic test_flush();
    int n0;
    fixed_lat = 5;
    n0 = n_if_valid;
    fq.push_back(32'h20); fflush_q.push_back(2);
    fq.push_back(32'h24); fflush_q.push_back(4);
    fq.push_back(32'h80); fflush_q.push_back(-1);
    run_until_idle(60);
    vectors++;
    if (n_if_valid - n0 != 1 || last_if_data !== init_word(32'h80) || bus.mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL flush: got %0d valids data=%h mem_req=%b expected 1 valid data=%h mem_req=0",
               n_if_valid - n0, last_if_data, bus.mem_req, init_word(32'h80));
    end
  endtask

  task automatic test_long_latency();
    dop_t op;
    fixed_lat = 6;
    max_hi = 0;
    op.we = 1'b0; op.addr = 32'h44; op.wdata = 32'h0;
    dq.push_back(op);
    run_until_idle(30);
    vectors++;
    if (max_hi != 6) begin
      miscompares++;
      $display("FAIL long_latency: got mem_req high %0d cycles expected 6", max_hi);
    end
  endtask

  task automatic test_reset_mid();
    dop_t op;
    int n0, guard;
    fixed_lat = 20;
    op.we = 1'b0; op.addr = 32'h48; op.wdata = 32'h0;
    dq.push_back(op);
    guard = 0;
    while (!(open && cnt >= 3) && guard < 20) begin
      step();
      guard++;
    end
    vectors++;
    if (!open) begin
      miscompares++;
      $display("FAIL reset_mid_setup: got no open transaction expected BUSY_D");
    end
    n0 = n_d_valid;
    reset_dut(1);
    bus.mem_ack = 1'b1;
    step();
    step();
    vectors++;
    if (n_d_valid != n0 || bus.d_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_stray_ack: got d_valid=%b mem_req=%b extra=%0d expected 0 0 0",
               bus.d_valid, bus.mem_req, n_d_valid - n0);
    end
  endtask

  task automatic test_spurious_ack();
    int ni, nd;
    ni = n_if_valid; nd = n_d_valid;
    bus.mem_ack = 1'b1;
    repeat (3) step();
    vectors++;
    if (n_if_valid != ni || n_d_valid != nd || bus.mem_req !== 1'b0 || bus.if_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL spurious_ack: got mem_req=%b if_valid=%b expected 0 0", bus.mem_req, bus.if_valid);
    end
  endtask

  task automatic test_random();
    int ni, nd;
    reset_dut(1);
    fixed_lat = 0;
    ni = n_if_valid; nd = n_d_valid;
    rand_mode = 1;
    repeat (600) step();
    rand_mode = 0;
    run_until_idle(200);
    vectors++;
    if (n_if_valid == ni || n_d_valid == nd) begin
      miscompares++;
      $display("FAIL random_progress: got %0d fetch and %0d data completions expected both nonzero",
               n_if_valid - ni, n_d_valid - nd);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ack = 1'b0;
    test_reset();
    test_fetch_only();
    test_store_load();
    test_contention();
    test_flush();
    test_long_latency();
    test_reset_mid();
    test_spurious_ack();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
